e_mdu_iter: RTL
===============

E_MDU_ITER -- requirements
Module: e_mdu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; hi/lo each WIDTH bits; legal values are even and >= 8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset; when low, state is cleared at the next clk edge.
REQ-004 SHALL have port req  input  1  exception/flush; when high, cancels any in-flight operation and accepts no new one.
REQ-005 SHALL have port A  input  WIDTH  rs operand: multiplicand, dividend, or mthi/mtlo source.
REQ-006 SHALL have port B  input  WIDTH  rt operand: multiplier or divisor.
REQ-007 SHALL have port E_sel_MDU  input  4  op code, 0 = none, as defined in the shared package.
REQ-008 SHALL have port E_mdu  output  WIDTH  combinational: hi for mfhi, lo for mflo, 0 otherwise.
REQ-009 SHALL have port busy  output  1  registered; high while an operation is in flight.
REQ-010 SHALL have port start  output  1  combinational: high when E_sel_MDU is mult, multu, div, divu, madd, maddu, msub or msubu, regardless of busy.

Function
REQ-011 SHALL use op codes mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8, madd=9, maddu=10, msub=11, msubu=12; codes 0 and 13-15 are no-ops.
REQ-012 SHALL implement states IDLE, MUL, DIV and FIX.
REQ-013 SHALL accept an op only in IDLE with req=0; an op presented while busy=1 SHALL be ignored with no side effect.
REQ-014 SHALL, on mthi or mtlo accepted in IDLE, write A to hi or lo at that edge, with busy remaining 0.
REQ-015 SHALL, on a multiply-class op accepted in IDLE, latch operand magnitudes and signs and enter MUL; divide-class ops enter DIV.
REQ-016 SHALL perform MUL as radix-2 shift-add and DIV as radix-2 restoring division, one bit per cycle, for exactly WIDTH cycles, then spend one cycle in FIX before returning to IDLE.
REQ-017 SHALL, in FIX, apply sign correction and the accumulate step, and commit hi/lo at the edge that leaves FIX.
REQ-018 SHALL set latency so that busy is high for exactly WIDTH+1 cycles starting the cycle after issue, and an mfhi/mflo issued in the cycle after busy falls returns the new value.
REQ-019 SHALL keep E_mdu showing the old hi/lo while busy=1, since the pipeline stalls on start|busy.
REQ-020 SHALL compute signed mult as the exact 2*WIDTH two's-complement product and multu as the unsigned product.
REQ-021 SHALL compute madd/maddu as {hi,lo} + product and msub/msubu as {hi,lo} - product, modulo 2^(2*WIDTH), using hi/lo as held at FIX.
REQ-022 SHALL give signed div a quotient truncated toward zero and a remainder with the sign of the dividend.
REQ-023 SHALL, on divide by zero, return lo = all ones and hi = A, with the same latency as a normal divide.
REQ-024 SHALL, on signed overflow (A = most negative, B = -1), return lo = A and hi = 0.
REQ-025 SHALL, when req=1 in any state, next enter IDLE with busy=0, leave hi/lo unchanged, discard partial results, and accept no op that cycle.
REQ-026 SHALL let req=1 in the same cycle as an issue override the issue.

Reset
REQ-027 SHALL, with reset low at an edge, set hi=0, lo=0, state IDLE, busy=0 and clear all iteration registers, overriding req and any op.
REQ-028 SHALL, on reset mid-operation, abandon the operation with no hi/lo commit, so that hi=lo=0 after reset.
REQ-029 SHALL have E_mdu and start combinational only and unaffected by reset.

Structure
REQ-030 SHALL place op-code constants and the state enumeration in shared package mdu_pkg.
REQ-031 SHALL place the divide datapath (partial remainder, quotient shift, one step per cycle) in sub-module mdu_div_step; multiply and FIX stay in e_mdu_iter.

Verification
REQ-032 SHALL cover, with WIDTH=32: mult A=0xFFFFFFFF, B=2 -> busy high 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=1, lo=0xFFFFFFFE.
REQ-033 SHALL cover: divu 100/7 -> lo=14, hi=2; div 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 SHALL cover: div 5/0 -> lo=0xFFFFFFFF, hi=5; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 SHALL cover: mthi 0, mtlo 0xFFFFFFFF, then madd 1*1 -> hi=1, lo=0; then mthi 0, mtlo 0, msubu 1*1 -> hi=lo=0xFFFFFFFF.
REQ-036 SHALL cover: hi=lo=0x12345678, issue mult 3*4, req=1 on the 10th busy cycle -> busy=0 next cycle, hi/lo remain 0x12345678; a new mult 3*4 after req drops -> lo=12.
REQ-037 SHALL cover: reset low during an in-flight divu -> busy=0 and hi=lo=0 after the edge; an op issued while busy=1 produces no state change.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module : mdu_pkg
// Brief  : Shared op codes, FSM states and op-class helpers for e_mdu_iter.
// Rev    : 1.0
// ============================================================================
package mdu_pkg;

    localparam logic [3:0] c_OP_NONE  = 4'd0;
    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MFHI  = 4'd5;
    localparam logic [3:0] c_OP_MFLO  = 4'd6;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;
    localparam logic [3:0] c_OP_MADD  = 4'd9;
    localparam logic [3:0] c_OP_MADDU = 4'd10;
    localparam logic [3:0] c_OP_MSUB  = 4'd11;
    localparam logic [3:0] c_OP_MSUBU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    function automatic logic op_is_mul(input logic [3:0] op);
        return (op == c_OP_MULT) || (op == c_OP_MULTU) ||
               (op == c_OP_MADD) || (op == c_OP_MADDU) ||
               (op == c_OP_MSUB) || (op == c_OP_MSUBU);
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == c_OP_DIV) || (op == c_OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == c_OP_MULT) || (op == c_OP_DIV) ||
               (op == c_OP_MADD) || (op == c_OP_MSUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/e_mdu_iter_if.sv
`default_nettype none
// ============================================================================
// Module : e_mdu_iter_if
// Brief  : Pipeline-to-MDU bus: operands, op select, flush, result and status.
// Rev    : 1.0
// ============================================================================
interface e_mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       E_sel_MDU;
    logic [WIDTH-1:0] E_mdu;
    logic             busy;
    logic             start;

    modport master (output req, A, B, E_sel_MDU, input E_mdu, busy, start);
    modport slave  (input req, A, B, E_sel_MDU, output E_mdu, busy, start);
endinterface
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// ============================================================================
// Module : mdu_div_step
// Brief  : Unsigned radix-2 restoring divider, one quotient bit per step.
// Rev    : 1.0
// ============================================================================
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic             step,
    input  wire logic [WIDTH-1:0] dividend,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH-1:0] quot,
    output logic      [WIDTH-1:0] rem
);
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    // Quotient register doubles as the dividend shifter; its MSB feeds the remainder.
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_div  <= '0;
        end else if (load) begin
            r_rem  <= '0;
            r_quot <= dividend;
            r_div  <= divisor;
        end else if (step) begin
            r_rem  <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quot <= {r_quot[WIDTH-2:0], w_ge};
        end
    end

    assign quot = r_quot;
    assign rem  = r_rem;
endmodule
`default_nettype wire

// File: rtl/e_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module : e_mdu_iter
// Brief  : Iterative multiply/divide unit with hi/lo, WIDTH+1 cycle latency.
// Rev    : 1.0
// ============================================================================
module e_mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic     clk,
    input  wire logic     reset,
    e_mdu_iter_if.slave   mdu
);
    localparam int c_CW = $clog2(WIDTH);

    state_t             r_state;
    logic               r_busy;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic [WIDTH-1:0]   r_mh, r_ml, r_mcand, r_a;
    logic [3:0]         r_op;
    logic               r_neg_q, r_neg_r, r_dz;
    logic [c_CW-1:0]    r_cnt;

    logic [3:0]         w_op;
    logic               w_issue, w_sa, w_sb, w_div_load;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quot, w_rem, w_q, w_r;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod_s, w_acc;
    logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

    assign w_op       = mdu.E_sel_MDU;
    assign w_issue    = (r_state == ST_IDLE) && !mdu.req;
    assign w_sa       = op_is_signed(w_op) && mdu.A[WIDTH-1];
    assign w_sb       = op_is_signed(w_op) && mdu.B[WIDTH-1];
    assign w_mag_a    = w_sa ? -mdu.A : mdu.A;
    assign w_mag_b    = w_sb ? -mdu.B : mdu.B;
    assign w_div_load = w_issue && op_is_div(w_op);

    assign mdu.start  = op_is_mul(w_op) || op_is_div(w_op);
    assign mdu.busy   = r_busy;
    assign mdu.E_mdu  = (w_op == c_OP_MFHI) ? r_hi :
                        (w_op == c_OP_MFLO) ? r_lo : '0;

    mdu_div_step #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (w_div_load),
        .step     (r_state == ST_DIV),
        .dividend (w_mag_a),
        .divisor  (w_mag_b),
        .quot     (w_quot),
        .rem      (w_rem)
    );

    // Shift-add: the multiplier drains out of r_ml as product bits shift in.
    assign w_sum    = {1'b0, r_mh} + (r_ml[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_s = r_neg_q ? -{r_mh, r_ml} : {r_mh, r_ml};
    assign w_acc    = {r_hi, r_lo};
    assign w_q      = r_neg_q ? -w_quot : w_quot;
    assign w_r      = r_neg_r ? -w_rem : w_rem;

    always_comb begin
        w_fix_hi = r_hi;
        w_fix_lo = r_lo;
        case (r_op)
            c_OP_MULT, c_OP_MULTU: {w_fix_hi, w_fix_lo} = w_prod_s;
            c_OP_MADD, c_OP_MADDU: {w_fix_hi, w_fix_lo} = w_acc + w_prod_s;
            c_OP_MSUB, c_OP_MSUBU: {w_fix_hi, w_fix_lo} = w_acc - w_prod_s;
            c_OP_DIV, c_OP_DIVU: begin
                w_fix_hi = r_dz ? r_a : w_r;
                w_fix_lo = r_dz ? '1  : w_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_mh    <= '0;
            r_ml    <= '0;
            r_mcand <= '0;
            r_a     <= '0;
            r_op    <= c_OP_NONE;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_cnt   <= '0;
        end else if (mdu.req) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_op == c_OP_MTHI) r_hi <= mdu.A;
                    if (w_op == c_OP_MTLO) r_lo <= mdu.A;
                    if (op_is_mul(w_op) || op_is_div(w_op)) begin
                        r_op    <= w_op;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        r_dz    <= (mdu.B == '0);
                        r_a     <= mdu.A;
                        r_mh    <= '0;
                        r_ml    <= w_mag_b;
                        r_mcand <= w_mag_a;
                        r_state <= op_is_mul(w_op) ? ST_MUL : ST_DIV;
                    end
                end
                ST_MUL: begin
                    r_mh  <= w_sum[WIDTH:1];
                    r_ml  <= {w_sum[0], r_ml[WIDTH-1:1]};
                    r_cnt <= r_cnt + c_CW'(1);
                    if (r_cnt == c_CW'(WIDTH-1)) r_state <= ST_FIX;
                end
                ST_DIV: begin
                    r_cnt <= r_cnt + c_CW'(1);
                    if (r_cnt == c_CW'(WIDTH-1)) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
